fetch_stage: RTL

Instruction-fetch front end of the 5-stage MIPS pipeline, consuming the stall/flush/redirect controls produced by hazard detection. It owns the PC, drives a single-outstanding request/response interface to instruction memory, and loads the IF/ID pipeline register. It holds at most one returned-but-unconsumed instruction in a skid entry. Missing instructions become bubbles (`validD`=0, `instrD`=NOP), so memory latency never stalls downstream stages.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_skid_buf.sv | 39 +++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, fetch FSM states, default reset PC.
package mips_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetchState_t;

   // Instruction fetches are word aligned; the low two address bits are dropped.
   function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a returned instruction that IF/ID could not accept.
// Clear beats load, load beats drain.
module fetch_skid_buf
   import mips_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load,
   input  logic            drain,
   input  logic            clear,
   input  logic [XLEN-1:0] loadInstr,
   input  logic [XLEN-1:0] loadPc,
   output logic            full,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc
);

   // Occupancy flag and payload.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         full  <= 1'b0;
         instr <= NOP;
         pc    <= '0;
      end else begin
         if (clear) begin
            full <= 1'b0;
         end else if (load) begin
            full <= 1'b1;
         end else if (drain) begin
            full <= 1'b0;
         end
         if (load && !clear) begin
            instr <= loadInstr;
            pc    <= loadPc;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem interface, skid entry, IF/ID register.
// Optional FETCH_PERF_EN adds saturating bubble/redirect counters.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stallF,
   input  logic            stallD,
   input  logic            redirectD,
   input  logic [XLEN-1:0] redirect_pcD,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] pcF,
   output logic [XLEN-1:0] instrD,
   output logic [XLEN-1:0] pcplus4D,
   output logic            validD
`ifdef FETCH_PERF_EN
   ,
   output logic [XLEN-1:0] perf_bubbles,
   output logic [XLEN-1:0] perf_redirects
`endif
);

   fetchState_t     state, stateNext;
   logic [XLEN-1:0] addrQ;      // address held stable while a request awaits gnt
   logic [XLEN-1:0] flPc;       // PC of the granted request
   logic            dead;       // pending/in-flight request must be dropped
   logic [XLEN-1:0] pcNext;

   logic            redirAcc, rspHere, rspAlive, grant, reqLive, reqEarly;
   logic            skidLoad, skidDrain, skidFull, skidFullNext;
   logic [XLEN-1:0] skidInstr, skidPc;

   // Control decode shared by the FSM and the datapath.
   assign redirAcc     = redirectD & ~stallD;
   assign rspHere      = (state == WAIT) & imem_rvalid;
   assign rspAlive     = rspHere & ~dead & ~redirAcc;
   assign skidLoad     = rspAlive & (stallD | skidFull);
   assign skidDrain    = ~stallD & skidFull;
   assign skidFullNext = ~redirAcc & (skidLoad | (skidFull & ~skidDrain));
   assign grant        = imem_req & imem_gnt;
   assign reqLive      = (state == REQ) ? ~dead : 1'b1;
   assign pcNext       = redirAcc          ? wordAlign(redirect_pcD) :
                         (grant & reqLive) ? pcF + XLEN'(4)          : pcF;

   // Fetch FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= stateNext;
   end

   // Next state and request outputs; a new request may go out in the response cycle.
   always_comb begin
      stateNext = state;
      imem_req  = 1'b0;
      imem_addr = '0;
      reqEarly  = 1'b0;
      case (state)
         IDLE: begin
            if (!stallF && !skidFull) stateNext = REQ;
         end
         REQ: begin
            imem_req  = 1'b1;
            imem_addr = addrQ;
            if (imem_gnt) stateNext = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (!stallF && !skidFullNext) begin
                  reqEarly  = 1'b1;
                  imem_req  = 1'b1;
                  imem_addr = pcF;
                  stateNext = imem_gnt ? WAIT : REQ;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // PC, request bookkeeping and dead tracking.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pcF   <= RESET_PC;
         addrQ <= '0;
         flPc  <= '0;
         dead  <= 1'b1;
      end else begin
         pcF <= pcNext;
         if (imem_req && !imem_gnt) addrQ <= imem_addr;
         else                       addrQ <= pcNext;
         if (grant) flPc <= imem_addr;
         if (imem_req)            dead <= ~reqLive | redirAcc;
         else if (state == WAIT)  dead <= dead | redirAcc;
         else                     dead <= 1'b0;
      end
   end

   fetch_skid_buf uSkid (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (skidLoad),
      .drain     (skidDrain),
      .clear     (redirAcc),
      .loadInstr (imem_rdata),
      .loadPc    (flPc),
      .full      (skidFull),
      .instr     (skidInstr),
      .pc        (skidPc)
   );

   // IF/ID register: skid first, then the live response, otherwise a bubble.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         instrD   <= NOP;
         pcplus4D <= '0;
         validD   <= 1'b0;
      end else if (!stallD) begin
         if (redirAcc) begin
            instrD   <= NOP;
            pcplus4D <= '0;
            validD   <= 1'b0;
         end else if (skidFull) begin
            instrD   <= skidInstr;
            pcplus4D <= skidPc + XLEN'(4);
            validD   <= 1'b1;
         end else if (rspAlive) begin
            instrD   <= imem_rdata;
            pcplus4D <= flPc + XLEN'(4);
            validD   <= 1'b1;
         end else begin
            instrD   <= NOP;
            pcplus4D <= '0;
            validD   <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic bubbleLoad;
   assign bubbleLoad = ~stallD & (redirAcc | (~skidFull & ~rspAlive));

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_bubbles   <= '0;
         perf_redirects <= '0;
      end else begin
         if (bubbleLoad && (perf_bubbles != '1))   perf_bubbles   <= perf_bubbles + XLEN'(1);
         if (redirAcc && (perf_redirects != '1))   perf_redirects <= perf_redirects + XLEN'(1);
      end
   end
`endif

endmodule
